// File: rtl/lfsr_seq_ctrl_if.sv
// Command and burst-sample channels of the LFSR sequencer.
// The host drives commands and accepts samples; the sequencer does the reverse.
interface lfsr_seq_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_arg;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // Host side: offers commands, sinks burst samples.
   modport master (
      output cmd_valid, cmd_op, cmd_arg, out_ready,
      input  cmd_ready, out_valid, out_data
   );

   // Sequencer side.
   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, out_ready,
      output cmd_ready, out_valid, out_data
   );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer for an external 8-bit LFSR register.
// Issues load/step strobes for seeding, counted bursts (each new state is
// streamed over a valid/ready port) and prescaled free-run, and owns the LED
// register that mirrors the LFSR state.
module lfsr_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   lfsr_seq_ctrl_if.slave   bus,
   output logic             lfsr_load_o,
   output logic [WIDTH-1:0] lfsr_seed_o,
   output logic             lfsr_en_o,
   input  logic [WIDTH-1:0] lfsr_q_i,
   output logic [WIDTH-1:0] led_o,
   output logic             busy_o
);

   localparam int               DIV_W    = 16;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_BURST = 2'b01;
   localparam logic [1:0] OP_FREE  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STEP,
      S_OUT,
      S_FREE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH-1:0] led_q;
   logic             upd_q;
   logic             rdy_en_q;   // keeps cmd_ready low until the first edge out of reset
   logic             cmd_ready;
   logic             cmd_fire;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [WIDTH-1:0] arg_seed;

   assign arg_seed = bus.cmd_arg[WIDTH-1:0];

   // Next-state, counters and Moore strobes; an accepted command overrides the state's own transition.
   always_comb begin
      state_d     = state_q;
      remain_d    = remain_q;
      div_cnt_d   = div_cnt_q;
      seed_d      = seed_q;
      cmd_ready   = 1'b0;
      cmd_fire    = 1'b0;
      lfsr_load_o = 1'b0;
      lfsr_en_o   = 1'b0;
      out_valid   = 1'b0;
      unique case (state_q)
         S_IDLE: cmd_ready = rdy_en_q;
         S_LOAD: begin
            lfsr_load_o = 1'b1;
            state_d     = S_IDLE;
         end
         S_STEP: begin
            lfsr_en_o = 1'b1;
            state_d   = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               remain_d = remain_q - CNT_W'(1);
               state_d  = (remain_q == CNT_W'(1)) ? S_IDLE : S_STEP;
            end
         end
         S_FREE: begin
            cmd_ready = rdy_en_q;
            if (div_cnt_q == DIV_LAST) begin
               lfsr_en_o = 1'b1;
               div_cnt_d = '0;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      cmd_fire = cmd_ready & bus.cmd_valid;
      if (cmd_fire) begin
         unique case (bus.cmd_op)
            OP_LOAD: begin
               state_d = S_LOAD;
               // All-zero is the LFSR lockup state, so it is never loaded.
               seed_d  = (arg_seed == '0) ? WIDTH'(1) : arg_seed;
            end
            OP_BURST: begin
               if (bus.cmd_arg != '0) begin
                  state_d  = S_STEP;
                  remain_d = bus.cmd_arg;
               end else begin
                  state_d = S_IDLE;
               end
            end
            OP_FREE: begin
               state_d   = S_FREE;
               div_cnt_d = '0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         remain_q  <= '0;
         div_cnt_q <= '0;
         seed_q    <= '0;
         rdy_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         div_cnt_q <= div_cnt_d;
         seed_q    <= seed_d;
         rdy_en_q  <= 1'b1;
      end
   end

   // LED picks up the LFSR output the cycle after the register has taken a strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         upd_q <= 1'b0;
         led_q <= '0;
      end else begin
         upd_q <= lfsr_en_o | lfsr_load_o;
         if (upd_q) begin
            led_q <= lfsr_q_i;
         end
      end
   end

   // Sample bus is forced to zero whenever no beat is offered.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_out_data
         assign out_data[gi] = out_valid & lfsr_q_i[gi];
      end
   endgenerate

   assign bus.cmd_ready = cmd_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign lfsr_seed_o   = seed_q;
   assign led_o         = led_q;
   assign busy_o        = (state_q != S_IDLE);

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Command-driven sequencer for the 8-bit LFSR datapath. It sits between a host command source and an external LFSR register, and drives that register's load and step strobes. Three step modes are supported: seeding, a counted burst of steps with each new state streamed out over a valid/ready port, and prescaled free-running for the board LEDs. It also owns the `Led` register, so the LFSR core stays a pure shift register.

## Interface
- `WIDTH`, 8: LFSR / seed / data width.
- `CNT_W`, 16: width of `cmd_arg` and the burst step counter.
- `DIV`, 1: free-run prescale. One step every `DIV` cycles. Legal range is 1..2^16-1.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` is high at a rising edge.
- `cmd_op`  in  2  command code: 00 LOAD, 01 BURST, 10 FREERUN, 11 STOP.
- `cmd_arg`  in  `CNT_W`  LOAD: seed, taken from the low `WIDTH` bits. BURST: step count N. Ignored otherwise.
- `lfsr_load`  out  1  one-cycle strobe; the LFSR loads `lfsr_seed` at that edge.
- `lfsr_seed`  out  `WIDTH`  seed value, meaningful only while `lfsr_load` is high.
- `lfsr_en`  out  1  one-cycle step strobe; the LFSR advances at that edge.
- `lfsr_q`  in  `WIDTH`  registered LFSR state.
- `out_valid`  out  1  burst sample valid.
- `out_ready`  in  1  sink ready.
- `out_data`  out  `WIDTH`  burst sample, equal to `lfsr_q` while `out_valid` is high.
- `Led`  out  `WIDTH`  latest LFSR state, registered.
- `busy`  out  1  high when the state is not IDLE.

## Operation
States and transitions:
- **IDLE**
  - `cmd_ready=1`.
  - LOAD → LOAD.
  - BURST with N>0 → STEP, with `remain=N`.
  - BURST with N=0 → stay in IDLE. The command is consumed; no strobe and no output.
  - FREERUN → FREE, with `div_cnt=0`.
  - STOP → stay in IDLE (no-op).
- **LOAD**
  - `lfsr_load=1`.
  - `lfsr_seed = arg[WIDTH-1:0]`. A seed of 0 is replaced by 1, because the all-zero state is a lockup.
  - Next state: IDLE.
- **STEP**
  - `lfsr_en=1` for one cycle, then OUT.
- **OUT**
  - `out_valid=1`, `out_data=lfsr_q`.
  - `lfsr_en` stays 0, so the data is stable until the handshake.
  - On `out_ready`, `remain` decrements. Go to STEP if the new `remain` is nonzero, otherwise to IDLE.
- **FREE**
  - `cmd_ready=1`.
  - `lfsr_en=1` on cycles where `div_cnt==DIV-1`; `div_cnt` wraps to 0 on those cycles. With `DIV=1`, `lfsr_en` is high every FREE cycle.
  - An accepted command ends free-run and executes exactly as it would from IDLE (STOP → IDLE).
  - If a strobe is due in the accept cycle, it is still issued.
- `cmd_ready=0` in LOAD, STEP and OUT.
- `busy=0` only in IDLE.
- `Led` update:
  - `upd` is a register that holds `lfsr_en|lfsr_load` from the previous cycle.
  - When `upd=1`, `Led <= lfsr_q`.
  - Result: `Led` shows each new LFSR state 2 cycles after the strobe cycle.
- `remain` is `CNT_W` wide. N = 2^CNT_W-1 is legal; there is no wrap inside a burst.

## Timing
- Reset, when `rst_n=0` at an edge:
  - State → IDLE.
  - `cmd_ready` resets to 0 while `rst_n` is low and is 1 from the first cycle after release.
  - `lfsr_load=0`, `lfsr_en=0`, `lfsr_seed=0`, `out_valid=0`, `out_data=0`, `busy=0`, `Led=0`, `remain=0`, `div_cnt=0`, `upd=0`.
  - Reset takes effect mid-burst: `out_valid` drops even if a beat is pending, and no LFSR reload is issued.
- Timeline for a command accepted at edge T:
  - LOAD: `lfsr_load` high during cycle T+1. `lfsr_q`=seed from T+2. `cmd_ready` is 1 again in T+2.
  - BURST: `lfsr_en` high during T+1. `out_valid` high from T+2.
  - With `out_ready` held high, a beat completes every 2 cycles.
  - Cycle after the last handshake: IDLE, `cmd_ready=1`.
  - FREERUN: the first `lfsr_en` occurs in cycle T+DIV.
- Handshakes follow valid/ready rules:
  - `out_valid` never deasserts without a handshake, except on reset.
  - `out_data` is constant while it waits.
  - `cmd_valid` may be held high; only one command is consumed per accepting edge.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with random inputs → all outputs 0. Release → `cmd_ready=1` on the first post-release cycle.
- LOAD `0xA5` accepted at T → `lfsr_load=1` with `lfsr_seed=0xA5` only in T+1. `Led=0xA5` at T+3. LOAD `0x00` → `lfsr_seed=0x01`.
- BURST N=3, `out_ready=1`, after seed `0x01` → exactly 3 beats at T+2, T+4 and T+6, equal to successive model LFSR states. `busy=1` through T+6; `cmd_ready=1` at T+7. BURST N=0 → no strobe, no beat, `busy` stays 0.
- BURST N=2, `out_ready=0` for 5 cycles on beat 1 → `out_valid` held and `out_data` unchanged for 5 cycles, no `lfsr_en` during the stall. Beat 2 follows 2 cycles after the handshake.
- FREERUN with `DIV=4`, then STOP after 10 strobes → `lfsr_en` exactly every 4th cycle and `Led` tracks each state. No `lfsr_en` after the STOP accept cycle; IDLE follows.
- Mid-operation events:
  - Assert reset on cycle 3 of a BURST N=5 → `out_valid` drops at the next edge and no further strobes occur.
  - LOAD issued during FREE → free-run ends and the load pulse is issued next cycle.
